// File: rtl/rf_wb_arbiter_if.sv
// Register-file write-back bus: two producer request channels (ALU, LSU)
// plus the single register-file write port driven by the arbiter.
// master = producers / register file side, slave = rf_wb_arbiter.
interface rf_wb_arbiter_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32
);
  logic                      alu_valid;
  logic                      alu_ready;
  logic [REG_ADDR_WIDTH-1:0] alu_addr;
  logic [REG_DATA_WIDTH-1:0] alu_data;
  logic                      lsu_valid;
  logic                      lsu_ready;
  logic [REG_ADDR_WIDTH-1:0] lsu_addr;
  logic [REG_DATA_WIDTH-1:0] lsu_data;
  logic [REG_ADDR_WIDTH-1:0] wr_addr;
  logic [REG_DATA_WIDTH-1:0] wr_data;
  logic                      write_back_en;
  logic                      busy;

  modport master (
    output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
    input  alu_ready, lsu_ready, wr_addr, wr_data, write_back_en, busy
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
    output alu_ready, lsu_ready, wr_addr, wr_data, write_back_en, busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Write-back scheduler for the register file's single write port.
// ALU and LSU requests are buffered in per-source FIFOs (FIFO_DEPTH each),
// writes to x0 are swallowed at the input, and FIFO heads are granted
// round-robin, one registered write per clock.
// Optional macro RF_WB_STATS_EN adds saturating wb_count / x0_drop_count.
module rf_wb_arbiter #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  rf_wb_arbiter_if.slave bus
`ifdef RF_WB_STATS_EN
  ,
  output logic [15:0]    wb_count,
  output logic [15:0]    x0_drop_count
`endif
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  // Source index 0 = ALU, 1 = LSU
  logic [1:0]                in_valid_s;
  logic [REG_ADDR_WIDTH-1:0] in_addr_s [2];
  logic [REG_DATA_WIDTH-1:0] in_data_s [2];
  logic [1:0]                ready_s, accept_s, push_s, pop_s, nonempty_s;

  logic [REG_ADDR_WIDTH-1:0] addr_mem_r [2][FIFO_DEPTH];
  logic [REG_DATA_WIDTH-1:0] data_mem_r [2][FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_r [2];
  logic [PTR_W-1:0]          rd_ptr_r [2];
  logic [CNT_W-1:0]          count_r  [2];

  logic                      last_grant_r;
  logic                      grant_valid_s;
  logic                      grant_src_s;
  logic [REG_ADDR_WIDTH-1:0] head_addr_s;
  logic [REG_DATA_WIDTH-1:0] head_data_s;

  logic [REG_ADDR_WIDTH-1:0] wr_addr_r;
  logic [REG_DATA_WIDTH-1:0] wr_data_r;
  logic                      wb_en_r;

  assign in_valid_s   = {bus.lsu_valid, bus.alu_valid};
  assign in_addr_s[0] = bus.alu_addr;
  assign in_addr_s[1] = bus.lsu_addr;
  assign in_data_s[0] = bus.alu_data;
  assign in_data_s[1] = bus.lsu_data;

  // Per-source handshake flags; ready depends on the registered count only
  always_comb begin
    ready_s    = 2'b00;
    accept_s   = 2'b00;
    push_s     = 2'b00;
    nonempty_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ready_s[i]    = (count_r[i] != FULL_CNT);
      accept_s[i]   = in_valid_s[i] & ready_s[i];
      push_s[i]     = accept_s[i] & (in_addr_s[i] != {REG_ADDR_WIDTH{1'b0}});
      nonempty_s[i] = (count_r[i] != {CNT_W{1'b0}});
    end
  end

  // Round-robin grant: on contention the source that did not win last time goes
  always_comb begin
    grant_valid_s = 1'b0;
    grant_src_s   = SRC_ALU;
    case (nonempty_s)
      2'b11: begin
        grant_valid_s = 1'b1;
        grant_src_s   = (last_grant_r == SRC_ALU) ? SRC_LSU : SRC_ALU;
      end
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_src_s   = SRC_ALU;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_src_s   = SRC_LSU;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_src_s   = SRC_ALU;
      end
    endcase
  end

  assign pop_s       = {grant_valid_s & grant_src_s, grant_valid_s & ~grant_src_s};
  assign head_addr_s = addr_mem_r[grant_src_s][rd_ptr_r[grant_src_s]];
  assign head_data_s = data_mem_r[grant_src_s][rd_ptr_r[grant_src_s]];

  // FIFO storage; contents are only meaningful under a valid count, so no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push_s[i]) begin
        addr_mem_r[i][wr_ptr_r[i]] <= in_addr_s[i];
        data_mem_r[i][wr_ptr_r[i]] <= in_data_s[i];
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_r[i] <= {PTR_W{1'b0}};
        rd_ptr_r[i] <= {PTR_W{1'b0}};
        count_r[i]  <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + PTR_ONE;
        if (pop_s[i])  rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CNT_ONE;
          2'b01:   count_r[i] <= count_r[i] - CNT_ONE;
          default: count_r[i] <= count_r[i];
        endcase
      end
    end
  end

  // Registered write port; address/data hold their last value when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_r    <= {REG_ADDR_WIDTH{1'b0}};
      wr_data_r    <= {REG_DATA_WIDTH{1'b0}};
      wb_en_r      <= 1'b0;
      last_grant_r <= SRC_LSU;
    end else if (grant_valid_s) begin
      wr_addr_r    <= head_addr_s;
      wr_data_r    <= head_data_s;
      wb_en_r      <= 1'b1;
      last_grant_r <= grant_src_s;
    end else begin
      wb_en_r      <= 1'b0;
    end
  end

  assign bus.alu_ready     = ready_s[0];
  assign bus.lsu_ready     = ready_s[1];
  assign bus.wr_addr       = wr_addr_r;
  assign bus.wr_data       = wr_data_r;
  assign bus.write_back_en = wb_en_r;
  assign bus.busy          = (|nonempty_s) | wb_en_r;

`ifdef RF_WB_STATS_EN
  logic [1:0]  drop_s;
  logic [16:0] x0_next_s;
  logic [15:0] wb_cnt_r;
  logic [15:0] x0_cnt_r;

  // Accepted beats addressed to x0; both sources may drop in the same cycle
  always_comb begin
    drop_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      drop_s[i] = accept_s[i] & (in_addr_s[i] == {REG_ADDR_WIDTH{1'b0}});
    end
    x0_next_s = {1'b0, x0_cnt_r} + {16'h0000, drop_s[0]} + {16'h0000, drop_s[1]};
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_cnt_r <= 16'h0000;
      x0_cnt_r <= 16'h0000;
    end else begin
      if (wb_en_r && (wb_cnt_r != 16'hFFFF)) wb_cnt_r <= wb_cnt_r + 16'h0001;
      else                                   wb_cnt_r <= wb_cnt_r;
      if (x0_next_s[16]) x0_cnt_r <= 16'hFFFF;
      else               x0_cnt_r <= x0_next_s[15:0];
    end
  end

  assign wb_count      = wb_cnt_r;
  assign x0_drop_count = x0_cnt_r;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a random
// run checked against a queue-based reference model of the write-back rules.
module tb_rf_wb_arbiter;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW)) bus ();
`ifdef RF_WB_STATS_EN
  logic [15:0] wb_count;
  logic [15:0] x0_drop_count;
`endif

  rf_wb_arbiter #(.REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef RF_WB_STATS_EN
    .wb_count      (wb_count),
    .x0_drop_count (x0_drop_count),
`endif
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: per-source queues, last winner, expected port state
  beat_t   mq0[$], mq1[$];
  beat_t   stim0[$], stim1[$];
  beat_t   log_q[$];
  int      log_cyc[$];
  int      m_last;
  int      cyc;
  logic    exp_en, exp_rdy0, exp_rdy1, exp_busy;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  bit      acc0, acc1;
  int      exp_wb_cnt, exp_x0_cnt;
  logic [DW-1:0] m_rf [32];
  logic [DW-1:0] dut_rf [32];

  task automatic model_reset();
    mq0.delete(); mq1.delete(); stim0.delete(); stim1.delete();
    log_q.delete(); log_cyc.delete();
    m_last = 1; exp_en = 1'b0; exp_addr = '0; exp_data = '0;
    exp_rdy0 = 1'b1; exp_rdy1 = 1'b1; exp_busy = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0; exp_wb_cnt = 0; exp_x0_cnt = 0;
  endtask

  // Advance one clock: predict acceptance and grant from the queues, then update
  task automatic tick();
    bit r0, r1, a0, a1;
    int g;
    beat_t b0, b1, h;
    r0 = (mq0.size() < DEPTH);
    r1 = (mq1.size() < DEPTH);
    a0 = bus.alu_valid && r0;
    a1 = bus.lsu_valid && r1;
    b0.a = bus.alu_addr; b0.d = bus.alu_data;
    b1.a = bus.lsu_addr; b1.d = bus.lsu_data;
    if (mq0.size() > 0 && mq1.size() > 0) g = (m_last == 0) ? 1 : 0;
    else if (mq0.size() > 0) g = 0;
    else if (mq1.size() > 0) g = 1;
    else g = -1;
    @(posedge clk); #1;
    cyc++;
    if (exp_en && exp_wb_cnt < 65535) exp_wb_cnt++;
    h = '0;
    if (g == 0) h = mq0.pop_front();
    else if (g == 1) h = mq1.pop_front();
    if (g >= 0) begin
      exp_en = 1'b1; exp_addr = h.a; exp_data = h.d; m_last = g; m_rf[h.a] = h.d;
    end else begin
      exp_en = 1'b0;
    end
    if (a0) begin
      if (b0.a != '0) mq0.push_back(b0);
      else if (exp_x0_cnt < 65535) exp_x0_cnt++;
    end
    if (a1) begin
      if (b1.a != '0) mq1.push_back(b1);
      else if (exp_x0_cnt < 65535) exp_x0_cnt++;
    end
    acc0 = a0; acc1 = a1;
    exp_rdy0 = (mq0.size() < DEPTH);
    exp_rdy1 = (mq1.size() < DEPTH);
    exp_busy = (mq0.size() > 0) || (mq1.size() > 0) || exp_en;
  endtask

  // Present pending stimulus heads, clock once, retire accepted beats, log writes
  task automatic drive_cycle();
    beat_t tmp;
    if (stim0.size() > 0) begin
      bus.alu_valid = 1'b1; bus.alu_addr = stim0[0].a; bus.alu_data = stim0[0].d;
    end else begin
      bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    end
    if (stim1.size() > 0) begin
      bus.lsu_valid = 1'b1; bus.lsu_addr = stim1[0].a; bus.lsu_data = stim1[0].d;
    end else begin
      bus.lsu_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_data = '0;
    end
    tick();
    if (acc0) tmp = stim0.pop_front();
    if (acc1) tmp = stim1.pop_front();
    if (bus.write_back_en === 1'b1) begin
      tmp.a = bus.wr_addr; tmp.d = bus.wr_data;
      log_q.push_back(tmp); log_cyc.push_back(cyc);
      dut_rf[bus.wr_addr] = bus.wr_data;
    end
  endtask

  task automatic apply_reset();
    bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
    #3 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic beat_t mk(input int a, input int d);
    beat_t b;
    b.a = AW'(a);
    b.d = DW'(d);
    return b;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
    bus.alu_addr = '0; bus.lsu_addr = '0; bus.alu_data = '0; bus.lsu_data = '0;
    model_reset();
    #1;
    n_cmp++; if (bus.write_back_en !== 1'b0) begin n_err++; $display("FAIL reset_wb_en got %b exp 0", bus.write_back_en); end
    n_cmp++; if (bus.wr_addr !== 5'd0) begin n_err++; $display("FAIL reset_wr_addr got %h exp 0", bus.wr_addr); end
    n_cmp++; if (bus.wr_data !== 32'd0) begin n_err++; $display("FAIL reset_wr_data got %h exp 0", bus.wr_data); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_cmp++; if ({bus.alu_ready, bus.lsu_ready} !== 2'b11) begin n_err++; $display("FAIL reset_ready got %b%b exp 11", bus.alu_ready, bus.lsu_ready); end
    @(negedge clk); rst_n = 1'b1;
    // Fill both FIFOs, then reset asynchronously in the middle of a cycle
    stim0.push_back(mk(3, 32'h33)); stim0.push_back(mk(6, 32'h66));
    stim1.push_back(mk(4, 32'h44));
    drive_cycle(); drive_cycle();
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.write_back_en !== 1'b0) begin n_err++; $display("FAIL midreset_wb_en got %b exp 0", bus.write_back_en); end
    n_cmp++; if (bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin n_err++; $display("FAIL midreset_wr got %h/%h exp 0/0", bus.wr_addr, bus.wr_data); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy got %b exp 0", bus.busy); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle();
      n_cmp++; if (bus.write_back_en !== 1'b0) begin n_err++; $display("FAIL postreset_wb_en cycle %0d got %b exp 0", i, bus.write_back_en); end
    end
  endtask

  task automatic test_single_alu();
    stim0.push_back(mk(5, 32'hDEADBEEF));
    drive_cycle();
    n_cmp++; if (bus.write_back_en !== 1'b0) begin n_err++; $display("FAIL single_early got %b exp 0", bus.write_back_en); end
    drive_cycle();
    n_cmp++; if (bus.write_back_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single_write got en=%b %h/%h exp 1 05/deadbeef", bus.write_back_en, bus.wr_addr, bus.wr_data);
    end
    drive_cycle();
    n_cmp++; if (bus.write_back_en !== 1'b0 || bus.wr_addr !== 5'd5) begin
      n_err++; $display("FAIL single_after got en=%b addr=%h exp 0 05", bus.write_back_en, bus.wr_addr);
    end
  endtask

  task automatic test_contention();
    int exp_order[4] = '{1, 3, 2, 4};
    apply_reset();
    stim0.push_back(mk(1, 32'h11)); stim0.push_back(mk(2, 32'h22));
    stim1.push_back(mk(3, 32'h33)); stim1.push_back(mk(4, 32'h44));
    for (int i = 0; i < 7; i++) drive_cycle();
    n_cmp++; if (log_q.size() != 4) begin n_err++; $display("FAIL cont_count got %0d exp 4", log_q.size()); end
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      n_cmp++; if (log_q[k].a !== AW'(exp_order[k]) || log_q[k].d !== DW'(exp_order[k] * 17)) begin
        n_err++; $display("FAIL cont_order[%0d] got %h/%h exp %h", k, log_q[k].a, log_q[k].d, exp_order[k]);
      end
      n_cmp++; if (log_cyc[k] != log_cyc[0] + k) begin
        n_err++; $display("FAIL cont_consec[%0d] got cycle %0d exp %0d", k, log_cyc[k], log_cyc[0] + k);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] alu_seen[$], lsu_seen[$];
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      stim0.push_back(mk(20 + i, 32'hA000_0000 + 20 + i));
      stim1.push_back(mk(10 + i, 32'hB000_0000 + 10 + i));
    end
    drive_cycle(); drive_cycle();
    n_cmp++; if (bus.lsu_ready !== 1'b0) begin n_err++; $display("FAIL bp_lsu_ready got %b exp 0", bus.lsu_ready); end
    for (int i = 0; i < 10; i++) drive_cycle();
    foreach (log_q[k]) begin
      if (log_q[k].a >= 5'd20) alu_seen.push_back(log_q[k].a);
      else lsu_seen.push_back(log_q[k].a);
    end
    n_cmp++; if (alu_seen.size() != 3 || lsu_seen.size() != 3) begin
      n_err++; $display("FAIL bp_counts got alu=%0d lsu=%0d exp 3/3", alu_seen.size(), lsu_seen.size());
    end
    for (int k = 0; k < 3 && k < alu_seen.size() && k < lsu_seen.size(); k++) begin
      n_cmp++; if (alu_seen[k] !== AW'(20 + k) || lsu_seen[k] !== AW'(10 + k)) begin
        n_err++; $display("FAIL bp_order[%0d] got alu=%0d lsu=%0d exp %0d/%0d", k, alu_seen[k], lsu_seen[k], 20 + k, 10 + k);
      end
    end
  endtask

  task automatic test_x0_filter();
    apply_reset();
    stim0.push_back(mk(0, 32'hFF)); stim0.push_back(mk(7, 32'h77));
    for (int i = 0; i < 6; i++) drive_cycle();
    n_cmp++; if (log_q.size() != 1) begin n_err++; $display("FAIL x0_count got %0d exp 1", log_q.size()); end
    if (log_q.size() > 0) begin
      n_cmp++; if (log_q[0].a !== 5'd7 || log_q[0].d !== 32'h77) begin
        n_err++; $display("FAIL x0_write got %h/%h exp 07/00000077", log_q[0].a, log_q[0].d);
      end
    end
`ifdef RF_WB_STATS_EN
    n_cmp++; if (x0_drop_count !== 16'd1 || wb_count !== 16'd1) begin
      n_err++; $display("FAIL x0_stats got drop=%0d wb=%0d exp 1/1", x0_drop_count, wb_count);
    end
`endif
  endtask

  task automatic test_same_addr();
    apply_reset();
    stim0.push_back(mk(9, 32'hA)); stim1.push_back(mk(9, 32'hB));
    for (int i = 0; i < 5; i++) drive_cycle();
    n_cmp++; if (log_q.size() != 2) begin n_err++; $display("FAIL same_count got %0d exp 2", log_q.size()); end
    if (log_q.size() == 2) begin
      n_cmp++; if (log_q[0].d !== 32'hA || log_q[1].d !== 32'hB) begin
        n_err++; $display("FAIL same_order got %h,%h exp a,b", log_q[0].d, log_q[1].d);
      end
    end
    n_cmp++; if (dut_rf[9] !== 32'hB) begin n_err++; $display("FAIL same_final got %h exp b", dut_rf[9]); end
  endtask

  task automatic test_random();
    beat_t b;
    apply_reset();
    for (int i = 0; i < 420; i++) begin
      if (i < 400) begin
        if (stim0.size() == 0 && $urandom_range(0, 3) != 0) begin
          b.a = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
          b.d = $urandom; stim0.push_back(b);
        end
        if (stim1.size() == 0 && $urandom_range(0, 1) != 0) begin
          b.a = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
          b.d = $urandom; stim1.push_back(b);
        end
      end
      drive_cycle();
      n_cmp++; if (bus.alu_ready !== exp_rdy0 || bus.lsu_ready !== exp_rdy1) begin
        n_err++; $display("FAIL rnd_ready cyc %0d got %b%b exp %b%b", cyc, bus.alu_ready, bus.lsu_ready, exp_rdy0, exp_rdy1);
      end
      n_cmp++; if (bus.write_back_en !== exp_en || bus.wr_addr !== exp_addr || bus.wr_data !== exp_data) begin
        n_err++; $display("FAIL rnd_write cyc %0d got %b %h/%h exp %b %h/%h", cyc, bus.write_back_en, bus.wr_addr, bus.wr_data, exp_en, exp_addr, exp_data);
      end
      n_cmp++; if (bus.busy !== exp_busy) begin
        n_err++; $display("FAIL rnd_busy cyc %0d got %b exp %b", cyc, bus.busy, exp_busy);
      end
`ifdef RF_WB_STATS_EN
      n_cmp++; if (wb_count !== 16'(exp_wb_cnt) || x0_drop_count !== 16'(exp_x0_cnt)) begin
        n_err++; $display("FAIL rnd_stats cyc %0d got %0d/%0d exp %0d/%0d", cyc, wb_count, x0_drop_count, exp_wb_cnt, exp_x0_cnt);
      end
`endif
    end
    for (int r = 1; r < 32; r++) begin
      n_cmp++; if (dut_rf[r] !== m_rf[r]) begin
        n_err++; $display("FAIL rnd_regfile x%0d got %h exp %h", r, dut_rf[r], m_rf[r]);
      end
    end
  endtask

  initial begin
    cyc = 0;
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = '0;
      dut_rf[r] = '0;
    end
    test_reset();
    test_single_alu();
    test_contention();
    test_backpressure();
    test_x0_filter();
    test_same_addr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-back scheduler for the register file's single write port. It accepts write requests from two producers, the ALU and the load/store unit (LSU), over valid/ready handshakes. Requests are buffered in small per-source FIFOs and granted round-robin. It drives the register file's wr_addr, wr_data and write_back_en, one write per clock.

Parameters:
REG_ADDR_WIDTH, 5, register address width (32 architectural registers)
REG_DATA_WIDTH, 32, register data width
FIFO_DEPTH, 2, entries per source FIFO; power of two, minimum 2

Ports:
clk  input  1  single clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU write request valid
alu_ready  output  1  ALU FIFO can accept
alu_addr  input  REG_ADDR_WIDTH  ALU destination register
alu_data  input  REG_DATA_WIDTH  ALU result
lsu_valid  input  1  LSU write request valid
lsu_ready  output  1  LSU FIFO can accept
lsu_addr  input  REG_ADDR_WIDTH  LSU destination register
lsu_data  input  REG_DATA_WIDTH  load data
wr_addr  output  REG_ADDR_WIDTH  register file write address (registered)
wr_data  output  REG_DATA_WIDTH  register file write data (registered)
write_back_en  output  1  register file write strobe (registered)
busy  output  1  any FIFO non-empty or write_back_en high

Behaviour:
- Reset: rst_n low clears immediately, without waiting for clk. Both FIFOs become empty (pointers and counts zero). wr_addr, wr_data and write_back_en become 0. last_grant becomes LSU, so the ALU wins the first tie. Reset mid-operation discards all pending entries, and no write strobe is produced for them.
- Handshake: a beat transfers on posedge when valid && ready. ready = FIFO not full, a function of registered count only, with no combinational path from valid. A producer holds addr/data stable while valid && !ready.
- x0 filter: a beat with addr == 0 is accepted (ready honoured) but not enqueued. The register never sees a write to x0.
- Enqueue order is preserved per source. There is no ordering guarantee between sources.
- Arbitration, evaluated each cycle from the FIFO heads:
  - both empty: no grant
  - one non-empty: grant that source
  - both non-empty: grant the source != last_grant
  - on grant: pop the head, update last_grant
- Output stage: on posedge with a grant, wr_addr/wr_data take the head and write_back_en is 1. With no grant, write_back_en is 0 and wr_addr/wr_data hold their previous values.
- Latency: a beat accepted at edge N into an empty FIFO with no competing entry is popped at edge N+1. write_back_en is high for the cycle after edge N+1, and the register file commits at its next write edge.
- Throughput: exactly one write per cycle while any entry is pending.
- Full FIFO: ready low. If a pop and a valid beat occur in the same cycle, the beat is not accepted; ready rises the following cycle (no pass-through).
- Simultaneous enqueue and pop on a non-full FIFO: both take effect, and the count is unchanged.
- Same destination from both sources pending: written in grant order; the later grant's data is final.
- No storage beyond FIFO_DEPTH per source, and no internal forwarding.

Optional Feature:
Macro RF_WB_STATS_EN.
- Defined: adds output wb_count[15:0], which increments on every cycle write_back_en is 1. Also adds output x0_drop_count[15:0], which increments on every accepted beat to x0. Both counters saturate at 16'hFFFF and reset to 0 on rst_n.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with entries pending -> outputs 0 immediately, busy=0; after release, no write_back_en for the discarded entries.
- Single ALU write: alu_valid=1, addr=5, data=32'hDEADBEEF for one accepted beat -> one cycle later, write_back_en=1, wr_addr=5, wr_data=32'hDEADBEEF for exactly one cycle.
- Contention: ALU (addr 1, data 0x11), (addr 2, data 0x22) and LSU (addr 3, data 0x33), (addr 4, data 0x44) presented together each cycle -> write order 1,3,2,4, on consecutive cycles.
- Backpressure: LSU sends 3 beats back-to-back while ALU also streams, with FIFO_DEPTH=2 -> lsu_ready drops after 2 queued beats, no beat is lost or duplicated, and all writes appear in per-source order.
- x0 filter: ALU writes addr 0, data 0xFF, then addr 7, data 0x77 -> only the addr 7 write appears on the port. With RF_WB_STATS_EN, x0_drop_count=1 and wb_count=1.
- Same address: ALU addr 9, data 0xA and LSU addr 9, data 0xB pending together after reset -> the ALU write comes first, then the LSU write; final value 0xB.
